// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types for the UART receive path
package uart_pkg;

    // Widest frame the entry format can carry; narrower words are zero-extended.
    localparam int MAX_DATA_W = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } par_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } rx_state_t;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
        logic                  err_frame;
        logic                  err_parity;
    } rx_entry_t;

    // The unused encoding 2'b11 behaves as no parity.
    function automatic par_mode_t decode_parity(input logic [1:0] sel);
        case (sel)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - serial line deframer producing one FIFO entry per frame
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             rx,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       parity,
    input  logic             stop2,
    output rx_entry_t        word,
    output logic             push,
    output logic             busy
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    rx_state_t         state;
    rx_state_t         state_n;

    logic              rx_meta;
    logic              rx_sync;
    logic              rx_prev;

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_l;
    par_mode_t         par_l;
    logic              stop2_l;

    logic [BIT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              err_frame_r;
    logic              err_par_r;

    logic              mid_hit;
    logic              full_hit;

    logic              cnt_clr;
    logic              latch_cfg;
    logic              shift_en;
    logic              par_chk;
    logic              stop_chk;
    logic              finish;

    // The start bit is judged at its middle; every later bit lies a full period on.
    assign mid_hit  = (cnt == (div_l >> 1));
    assign full_hit = (cnt == div_l);
    assign busy     = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and per-cycle datapath strobes.
    always_comb begin
        state_n   = state;
        cnt_clr   = 1'b0;
        latch_cfg = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        stop_chk  = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_n   = ST_START;
                    cnt_clr   = 1'b1;
                    latch_cfg = 1'b1;
                end
            end
            ST_START: begin
                if (mid_hit) begin
                    cnt_clr = 1'b1;
                    state_n = rx_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (full_hit) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == BIT_W'(DATA_W - 1)) begin
                        state_n = (par_l != PAR_NONE) ? ST_PARITY : ST_STOP1;
                    end
                end
            end
            ST_PARITY: begin
                if (full_hit) begin
                    cnt_clr = 1'b1;
                    par_chk = 1'b1;
                    state_n = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (full_hit) begin
                    cnt_clr  = 1'b1;
                    stop_chk = 1'b1;
                    if (stop2_l) begin
                        state_n = ST_STOP2;
                    end else begin
                        state_n = ST_IDLE;
                        finish  = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (full_hit) begin
                    cnt_clr  = 1'b1;
                    stop_chk = 1'b1;
                    finish   = 1'b1;
                    state_n  = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Synchroniser, bit timer, frame config capture, shift register and result word.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            cnt         <= '0;
            div_l       <= '0;
            par_l       <= PAR_NONE;
            stop2_l     <= 1'b0;
            bit_idx     <= '0;
            shreg       <= '0;
            err_frame_r <= 1'b0;
            err_par_r   <= 1'b0;
            word        <= '0;
            push        <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            push    <= finish;

            cnt <= cnt_clr ? '0 : cnt + DIV_W'(1);

            if (latch_cfg) begin
                div_l       <= div;
                par_l       <= decode_parity(parity);
                stop2_l     <= stop2;
                bit_idx     <= '0;
                err_frame_r <= 1'b0;
                err_par_r   <= 1'b0;
            end

            if (shift_en) begin
                shreg   <= {rx_sync, shreg[DATA_W-1:1]};
                bit_idx <= bit_idx + BIT_W'(1);
            end

            if (par_chk) begin
                err_par_r <= (rx_sync != ((^shreg) ^ (par_l == PAR_ODD)));
            end

            if (stop_chk && !rx_sync) begin
                err_frame_r <= 1'b1;
            end

            // The final stop sample lands on this same edge, so fold it in directly.
            if (finish) begin
                word.data       <= MAX_DATA_W'(shreg);
                word.err_frame  <= err_frame_r | ~rx_sync;
                word.err_parity <= err_par_r;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with a DEPTH-entry receive FIFO and sticky overrun
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int DIV_W  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_rx,
    input  logic [DIV_W-1:0]           i_div,
    input  logic [1:0]                 i_parity,
    input  logic                       i_stop2,
    input  logic                       i_read,
    input  logic                       i_clr_ovr,
    output logic                       o_ready,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_err_frame,
    output logic                       o_err_parity,
    output logic                       o_overrun,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_busy
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    rx_entry_t        word;
    rx_entry_t        head;
    logic             push;

    rx_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             empty;
    logic             full;
    logic             do_read;
    logic             do_write;
    logic             drop;
    logic             unused_pad;

    uart_rx_deframer #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) u_deframer (
        .clk    (i_clk),
        .resetn (i_rst),
        .rx     (i_rx),
        .div    (i_div),
        .parity (i_parity),
        .stop2  (i_stop2),
        .word   (word),
        .push   (push),
        .busy   (o_busy)
    );

    // The extra wrap bit separates full from empty when the low bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                      (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign do_read  = i_read && !empty;
    assign do_write = push && (!full || do_read);
    assign drop     = push && full && !do_read;

    // Head entry straight from storage; storage is cleared on reset so it never reads X.
    assign head         = mem[rd_ptr[ADDR_W-1:0]];
    assign o_ready      = !empty;
    assign o_data       = head.data[DATA_W-1:0];
    assign o_err_frame  = head.err_frame;
    assign o_err_parity = head.err_parity;
    assign unused_pad   = ^(head.data >> DATA_W);

    // Storage, pointers, occupancy and sticky overrun.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            o_count   <= '0;
            o_overrun <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_write) begin
                mem[wr_ptr[ADDR_W-1:0]] <= word;
                wr_ptr                  <= wr_ptr + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_write && !do_read) begin
                o_count <= o_count + CNT_W'(1);
            end else if (do_read && !do_write) begin
                o_count <= o_count - CNT_W'(1);
            end
            if (drop) begin
                o_overrun <= 1'b1;
            end else if (i_clr_ovr) begin
                o_overrun <= 1'b0;
            end
        end
    end

endmodule
